// File: rtl/mac_stream_pkg.sv
// Shared types and constants for the streaming dot-product engine.
// No logic of its own; latency and flow control live in the modules that import it.
package mac_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int PIPE_DEPTH = 3;

  function automatic int prod_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/lane_sum_tree.sv
// Reduces LANES lane products to one ACC-width sum through a binary adder tree.
// One cycle of latency (output register); no flow control, it samples every cycle.
module lane_sum_tree #(
  parameter int LANES  = 8,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int SIGNED = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [LANES*IN_W-1:0] i_prod,
  output logic [OUT_W-1:0]      o_sum
);

  logic [OUT_W-1:0] w_node [LANES];
  logic [OUT_W-1:0] w_root;
  logic [OUT_W-1:0] r_sum;

  // In-place pairwise reduction: level of width w folds nodes 2j,2j+1 into j.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (SIGNED != 0) begin
        w_node[i] = OUT_W'($signed(i_prod[i*IN_W +: IN_W]));
      end else begin
        w_node[i] = OUT_W'(i_prod[i*IN_W +: IN_W]);
      end
    end
    for (int w = LANES / 2; w >= 1; w = w / 2) begin
      for (int j = 0; j < w; j++) begin
        w_node[j] = w_node[2*j] + w_node[2*j+1];
      end
    end
    w_root = w_node[0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= '0;
    end else begin
      r_sum <= w_root;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/mac_stream_engine.sv
// Lane-wise multiply, tree-reduce and accumulate a job of len beats into one dot product.
// Result valid 3 cycles after the last beat; in_ready only in RUN; result held until result_ready.
module mac_stream_engine
  import mac_stream_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 16,
  parameter int SIGNED = 0
) (
  input  logic                    clock,
  input  logic                    reset_l,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic [LANES*DATA_W-1:0] a_data,
  input  logic [LANES*DATA_W-1:0] b_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [ACC_W-1:0]        result,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    busy,
  output logic [15:0]             cycle_count
);

  localparam int PW = prod_w(DATA_W);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_in_ready;
  logic                    w_busy;
  logic                    w_accept;
  logic                    w_last_beat;
  logic                    w_final;
  logic [LEN_W-1:0]        r_beats;
  logic [LANES*DATA_W-1:0] r_a;
  logic [LANES*DATA_W-1:0] r_b;
  logic [LANES*PW-1:0]     w_prod;
  logic [LANES*PW-1:0]     r_prod;
  logic [ACC_W-1:0]        w_sum;
  logic [ACC_W-1:0]        w_acc_nxt;
  logic [ACC_W-1:0]        r_acc;
  logic [ACC_W-1:0]        r_result;
  logic                    r_result_valid;
  logic [PIPE_DEPTH-1:0]   r_vld;
  logic [PIPE_DEPTH-1:0]   r_last;
  logic [15:0]             r_cycle_count;

  assign w_accept    = in_valid & w_in_ready;
  assign w_last_beat = w_accept & (r_beats == LEN_W'(1));
  assign w_final     = r_vld[PIPE_DEPTH-1] & r_last[PIPE_DEPTH-1];
  assign w_acc_nxt   = r_acc + w_sum;

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // in_valid is read directly in RUN so the ready output never feeds back into this block.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_state_nxt = (len == '0) ? HOLD : RUN;
        end
      end
      RUN: begin
        w_in_ready = 1'b1;
        if (in_valid && (r_beats == LEN_W'(1))) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_final) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (r_result_valid && result_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sign- or zero-extend each lane to product width so one multiply serves both modes.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [PW-1:0] w_ax;
    logic signed [PW-1:0] w_bx;
    if (SIGNED != 0) begin : g_sx
      assign w_ax = PW'($signed(r_a[i*DATA_W +: DATA_W]));
      assign w_bx = PW'($signed(r_b[i*DATA_W +: DATA_W]));
    end else begin : g_zx
      assign w_ax = PW'(r_a[i*DATA_W +: DATA_W]);
      assign w_bx = PW'(r_b[i*DATA_W +: DATA_W]);
    end
    assign w_prod[i*PW +: PW] = w_ax * w_bx;
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      r_a    <= '0;
      r_b    <= '0;
      r_prod <= '0;
      r_vld  <= '0;
      r_last <= '0;
    end else begin
      r_vld  <= {r_vld[PIPE_DEPTH-2:0], w_accept};
      r_last <= {r_last[PIPE_DEPTH-2:0], w_last_beat};
      if (w_accept) begin
        r_a <= a_data;
        r_b <= b_data;
      end
      if (r_vld[0]) begin
        r_prod <= w_prod;
      end
    end
  end

  lane_sum_tree #(
    .LANES  (LANES),
    .IN_W   (PW),
    .OUT_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_tree (
    .i_clk   (clock),
    .i_rst_n (reset_l),
    .i_prod  (r_prod),
    .o_sum   (w_sum)
  );

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      r_beats        <= '0;
      r_acc          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_cycle_count  <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_beats       <= len;
        r_acc         <= '0;
        r_cycle_count <= '0;
        if (len == '0) begin
          r_result       <= '0;
          r_result_valid <= 1'b1;
        end
      end
      if (w_accept) begin
        r_beats <= r_beats - LEN_W'(1);
      end
      if (r_vld[PIPE_DEPTH-1]) begin
        r_acc <= w_acc_nxt;
      end
      if (r_state == DRAIN && w_final) begin
        r_result       <= w_acc_nxt;
        r_result_valid <= 1'b1;
      end
      if (r_state == HOLD && r_result_valid && result_ready) begin
        r_result_valid <= 1'b0;
      end
      if ((r_state == RUN || r_state == DRAIN) && r_cycle_count != 16'hFFFF) begin
        r_cycle_count <= r_cycle_count + 16'd1;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign busy         = w_busy;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign cycle_count  = r_cycle_count;

endmodule

// File: tb/tb_mac_stream_engine.sv
// Three engines (unsigned/32, signed/32, unsigned/16) share one stimulus stream;
// a reference dot-product model feeds per-instance expectation queues.
module tb_mac_stream_engine;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int VW    = LANES * DW;

  logic          clock        = 1'b0;
  logic          reset_l      = 1'b0;
  logic          start        = 1'b0;
  logic [15:0]   len          = '0;
  logic [VW-1:0] a_data       = '0;
  logic [VW-1:0] b_data       = '0;
  logic          in_valid     = 1'b0;
  logic          result_ready = 1'b1;

  logic        u_in_ready, u_result_valid, u_busy;
  logic [31:0] u_result;
  logic [15:0] u_cc;
  logic        s_in_ready, s_result_valid, s_busy;
  logic [31:0] s_result;
  logic [15:0] s_cc;
  logic        w_in_ready, w_result_valid, w_busy;
  logic [15:0] w_result;
  logic [15:0] w_cc;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_u [$];
  logic [31:0] exp_s [$];
  logic [15:0] exp_w [$];
  logic [31:0] sb_u, sb_s;
  logic [15:0] sb_w;

  always #5 clock = ~clock;

  mac_stream_engine #(.LANES(LANES), .DATA_W(DW), .ACC_W(32), .LEN_W(16), .SIGNED(0)) u_dut_u (
    .clock(clock), .reset_l(reset_l), .start(start), .len(len), .a_data(a_data), .b_data(b_data),
    .in_valid(in_valid), .in_ready(u_in_ready), .result(u_result), .result_valid(u_result_valid),
    .result_ready(result_ready), .busy(u_busy), .cycle_count(u_cc));

  mac_stream_engine #(.LANES(LANES), .DATA_W(DW), .ACC_W(32), .LEN_W(16), .SIGNED(1)) u_dut_s (
    .clock(clock), .reset_l(reset_l), .start(start), .len(len), .a_data(a_data), .b_data(b_data),
    .in_valid(in_valid), .in_ready(s_in_ready), .result(s_result), .result_valid(s_result_valid),
    .result_ready(result_ready), .busy(s_busy), .cycle_count(s_cc));

  mac_stream_engine #(.LANES(LANES), .DATA_W(DW), .ACC_W(16), .LEN_W(16), .SIGNED(0)) u_dut_w (
    .clock(clock), .reset_l(reset_l), .start(start), .len(len), .a_data(a_data), .b_data(b_data),
    .in_valid(in_valid), .in_ready(w_in_ready), .result(w_result), .result_valid(w_result_valid),
    .result_ready(result_ready), .busy(w_busy), .cycle_count(w_cc));

  function automatic longint dot(input logic [VW-1:0] a, input logic [VW-1:0] b, input bit sgn);
    longint s, x, y;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      if (sgn) begin
        x = longint'($signed(a[i*DW +: DW]));
        y = longint'($signed(b[i*DW +: DW]));
      end else begin
        x = longint'(a[i*DW +: DW]);
        y = longint'(b[i*DW +: DW]);
      end
      s = s + x * y;
    end
    return s;
  endfunction

  task automatic push_job(input int n, input logic [VW-1:0] av, input logic [VW-1:0] bv);
    longint pu, ps;
    pu = longint'(n) * dot(av, bv, 1'b0);
    ps = longint'(n) * dot(av, bv, 1'b1);
    exp_u.push_back(32'(pu));
    exp_s.push_back(32'(ps));
    exp_w.push_back(16'(pu));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every result handshake pops one expectation per instance.
  always @(negedge clock) begin
    if (reset_l && u_result_valid && result_ready) begin
      vectors++;
      if (exp_u.size() == 0 || exp_s.size() == 0 || exp_w.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_result: got u=%0d with no expectation queued", u_result);
      end else begin
        sb_u = exp_u.pop_front();
        sb_s = exp_s.pop_front();
        sb_w = exp_w.pop_front();
        if (u_result !== sb_u) begin
          miscompares++;
          $display("FAIL sb_unsigned32: got %h expected %h", u_result, sb_u);
        end
        vectors++;
        if (s_result_valid !== 1'b1 || s_result !== sb_s) begin
          miscompares++;
          $display("FAIL sb_signed32: got %h (valid %b) expected %h", s_result, s_result_valid, sb_s);
        end
        vectors++;
        if (w_result_valid !== 1'b1 || w_result !== sb_w) begin
          miscompares++;
          $display("FAIL sb_unsigned16: got %h (valid %b) expected %h", w_result, w_result_valid, sb_w);
        end
      end
    end
  end

  task automatic run_job(input int n, input logic [VW-1:0] av, input logic [VW-1:0] bv,
                         input int gap, input int exp_cc, input string name);
    int guard;
    int lat;
    push_job(n, av, bv);
    start = 1'b1;
    len   = 16'(n);
    tick();
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      a_data   = av;
      b_data   = bv;
      guard    = 0;
      while (u_in_ready !== 1'b1 && guard < 20) begin
        tick();
        guard++;
      end
      if (u_in_ready !== 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL %s_ready_timeout: in_ready %b expected 1 for beat %0d", name, u_in_ready, k);
      end
      tick();
      if (k < n - 1) begin
        in_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    vectors++;
    if (u_in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_ready_after_last: got %b expected 0", name, u_in_ready);
    end
    lat = 0;
    while (u_result_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
    vectors++;
    if (lat != 3) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles expected 3", name, lat);
    end
    vectors++;
    if (u_cc !== 16'(exp_cc)) begin
      miscompares++;
      $display("FAIL %s_cycle_count: got %0d expected %0d", name, u_cc, exp_cc);
    end
    tick();
    vectors++;
    if (u_busy !== 1'b0 || u_result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_back_to_idle: busy %b valid %b expected 0 0", name, u_busy, u_result_valid);
    end
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    repeat (2) tick();
    vectors++;
    if (u_busy !== 1'b0 || u_in_ready !== 1'b0 || u_result_valid !== 1'b0 ||
        u_result !== 32'd0 || u_cc !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy %b rdy %b vld %b res %h cc %0d expected all 0",
               u_busy, u_in_ready, u_result_valid, u_result, u_cc);
    end
    reset_l = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    run_job(2, 32'h04030201, 32'h08070605, 0, 5, "basic");
    vectors++;
    if (u_result !== 32'd140) begin
      miscompares++;
      $display("FAIL basic_result: got %0d expected 140", u_result);
    end
  endtask

  task automatic test_signed();
    run_job(1, 32'h0003FEFF, 32'h09FD04FF, 0, 4, "signed");
    vectors++;
    if (s_result !== 32'hFFFFFFF0) begin
      miscompares++;
      $display("FAIL signed_result: got %h expected fffffff0", s_result);
    end
  endtask

  task automatic test_bubbles();
    run_job(3, 32'h02020202, 32'h02020202, 1, 8, "bubbles");
    vectors++;
    if (u_result !== 32'd48) begin
      miscompares++;
      $display("FAIL bubbles_result: got %0d expected 48", u_result);
    end
  endtask

  task automatic test_len0_backpressure();
    result_ready = 1'b0;
    push_job(0, 32'h0, 32'h0);
    start = 1'b1;
    len   = 16'd0;
    tick();
    vectors++;
    if (u_result_valid !== 1'b1 || u_result !== 32'd0 || u_cc !== 16'd0 || u_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL len0_immediate: vld %b res %h cc %0d busy %b expected 1 0 0 1",
               u_result_valid, u_result, u_cc, u_busy);
    end
    for (int c = 0; c < 5; c++) begin
      start = 1'b1;
      len   = 16'd7;
      tick();
      vectors++;
      if (u_result_valid !== 1'b1 || u_result !== 32'd0 || u_in_ready !== 1'b0 || u_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_stable_%0d: vld %b res %h rdy %b busy %b expected 1 0 0 1",
                 c, u_result_valid, u_result, u_in_ready, u_busy);
      end
    end
    start        = 1'b0;
    result_ready = 1'b1;
    tick();
    vectors++;
    if (u_result_valid !== 1'b0 || u_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: vld %b busy %b expected 0 0", u_result_valid, u_busy);
    end
  endtask

  task automatic test_wrap();
    run_job(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 5, "wrap");
    vectors++;
    if (w_result !== 16'hF008) begin
      miscompares++;
      $display("FAIL wrap_result: got %h expected f008", w_result);
    end
  endtask

  task automatic test_reset_midjob();
    start = 1'b1;
    len   = 16'd3;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    a_data   = 32'h03030303;
    b_data   = 32'h03030303;
    repeat (4) tick();
    vectors++;
    if (u_busy !== 1'b1 || u_in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midjob_in_drain: busy %b rdy %b expected 1 0", u_busy, u_in_ready);
    end
    reset_l  = 1'b0;
    in_valid = 1'b0;
    #1;
    vectors++;
    if (u_busy !== 1'b0 || u_in_ready !== 1'b0 || u_result_valid !== 1'b0 ||
        u_result !== 32'd0 || u_cc !== 16'd0 || w_result !== 16'd0) begin
      miscompares++;
      $display("FAIL midjob_reset: busy %b rdy %b vld %b res %h cc %0d expected all 0",
               u_busy, u_in_ready, u_result_valid, u_result, u_cc);
    end
    repeat (2) tick();
    reset_l = 1'b1;
    tick();
    run_job(1, 32'h01010101, 32'h01010101, 0, 4, "after_reset");
    vectors++;
    if (u_result !== 32'd4) begin
      miscompares++;
      $display("FAIL after_reset_result: got %0d expected 4", u_result);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_bubbles();
    test_len0_backpressure();
    test_wrap();
    test_reset_midjob();
    repeat (3) tick();
    vectors++;
    if (exp_u.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d results never produced, expected 0", exp_u.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
